// File: rtl/axi_slave_mem_responder.sv
// AXI3 slave backed by a word-addressed 32-bit memory. Single and INCR bursts
// (1-16 beats), one outstanding transaction per direction, read/write concurrent.
module axi_slave_mem_responder #(
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 32,
  parameter int                MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ID_W-1:0]   WID,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
);

  localparam int              IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X     = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [1:0]      BURST_INCR  = 2'b01;
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;
  localparam logic [1:0]      RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // One extra bit so base index + beat count never wraps back into range.
  function automatic logic [ADDR_W:0] beat_index(input logic [ADDR_W-1:0] base,
                                                 input logic [3:0]        cnt);
    return {1'b0, base} + {{(ADDR_W-3){1'b0}}, cnt};
  endfunction

  logic [31:0] mem [MEM_DEPTH];
  logic        unused_inputs;

  assign unused_inputs = ^{AWSIZE, ARSIZE, WID};

  // ---------------- write path ----------------
  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   aw_id_q;
  logic [ADDR_W-1:0] aw_idx_q;
  logic              aw_below_q, aw_burst_err_q;
  logic [3:0]        aw_len_q, w_cnt_q;
  logic              w_dec_q, w_slv_q;
  logic              aw_hs, w_hs, b_hs;
  logic              w_last_beat, w_beat_ok, w_dec_all, w_slv_all, w_commit;
  logic [ADDR_W:0]   w_beat_idx;
  logic [31:0]       w_mask;

  assign aw_hs       = AWVALID & AWREADY;
  assign w_hs        = WVALID & WREADY;
  assign b_hs        = BVALID & BREADY;
  assign w_last_beat = (w_cnt_q == aw_len_q);
  assign w_beat_idx  = beat_index(aw_idx_q, w_cnt_q);
  assign w_beat_ok   = !aw_below_q && (w_beat_idx < DEPTH_X);
  assign w_dec_all   = w_dec_q | ~w_beat_ok;
  assign w_slv_all   = w_slv_q | (WLAST != w_last_beat) | aw_burst_err_q;
  assign w_commit    = w_hs & w_beat_ok & ~aw_burst_err_q;
  assign w_mask      = {{8{WSTRB[3]}}, {8{WSTRB[2]}}, {8{WSTRB[1]}}, {8{WSTRB[0]}}};

  always_comb begin
    // NOTE: default first, so no path through the case leaves w_state_d unassigned (no latch).
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      w_state_q      <= W_IDLE;
      AWREADY        <= 1'b0;
      WREADY         <= 1'b0;
      BVALID         <= 1'b0;
      BID            <= '0;
      BRESP          <= RESP_OKAY;
      aw_id_q        <= '0;
      aw_idx_q       <= '0;
      aw_below_q     <= 1'b0;
      aw_len_q       <= '0;
      aw_burst_err_q <= 1'b0;
      w_cnt_q        <= '0;
      w_dec_q        <= 1'b0;
      w_slv_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register here samples pre-edge values.
      w_state_q <= w_state_d;
      AWREADY   <= (w_state_d == W_IDLE);
      WREADY    <= (w_state_d == W_DATA);
      BVALID    <= (w_state_d == W_RESP);
      if (aw_hs) begin
        aw_id_q        <= AWID;
        aw_idx_q       <= (AWADDR - BASE_ADDR) >> 2;
        aw_below_q     <= (AWADDR < BASE_ADDR);
        aw_len_q       <= AWLEN;
        aw_burst_err_q <= (AWBURST != BURST_INCR) && (AWLEN != 4'd0);
        w_cnt_q        <= '0;
        w_dec_q        <= 1'b0;
        w_slv_q        <= 1'b0;
      end
      if (w_hs) begin
        w_dec_q <= w_dec_all;
        w_slv_q <= w_slv_all;
        if (w_last_beat) begin
          BID   <= aw_id_q;
          BRESP <= w_dec_all ? RESP_DECERR : (w_slv_all ? RESP_SLVERR : RESP_OKAY);
        end else begin
          w_cnt_q <= w_cnt_q + 4'd1;
        end
      end
    end
  end

  // NOTE: the memory is reset with everything else because its contents must read back as zero after every reset.
  for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_word
    logic [31:0] word_q;
    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        word_q <= '0;
      end else if (w_commit && (w_beat_idx[IDX_W-1:0] == IDX_W'(g))) begin
        word_q <= (word_q & ~w_mask) | (WDATA & w_mask);
      end
    end
    assign mem[g] = word_q;
  end

  // ---------------- read path ----------------
  r_state_e          r_state_q, r_state_d;
  logic [ADDR_W-1:0] ar_idx_q;
  logic              ar_below_q, ar_burst_err_q;
  logic [3:0]        ar_len_q, r_cnt_q;
  logic              ar_hs, r_hs, r_last_beat, r_load;
  logic [ADDR_W-1:0] f_base;
  logic              f_below, f_err, f_ok;
  logic [3:0]        f_cnt, f_len;
  logic [ADDR_W:0]   f_idx;
  logic [31:0]       f_data;
  logic [1:0]        f_resp;

  assign ar_hs       = ARVALID & ARREADY;
  assign r_hs        = RVALID & RREADY;
  assign r_last_beat = (r_cnt_q == ar_len_q);
  assign r_load      = ar_hs | (r_hs & ~r_last_beat);

  // Beat to present next: beat 0 straight from AR, otherwise the following beat.
  always_comb begin
    if (ar_hs) begin
      f_base  = (ARADDR - BASE_ADDR) >> 2;
      f_below = (ARADDR < BASE_ADDR);
      f_err   = (ARBURST != BURST_INCR) && (ARLEN != 4'd0);
      f_cnt   = '0;
      f_len   = ARLEN;
    end else begin
      f_base  = ar_idx_q;
      f_below = ar_below_q;
      f_err   = ar_burst_err_q;
      f_cnt   = r_cnt_q + 4'd1;
      f_len   = ar_len_q;
    end
    f_idx  = beat_index(f_base, f_cnt);
    f_ok   = !f_below && (f_idx < DEPTH_X);
    f_data = '0;
    f_resp = RESP_OKAY;
    if (!f_ok)      f_resp = RESP_DECERR;
    else if (f_err) f_resp = RESP_SLVERR;
    else            f_data = mem[f_idx[IDX_W-1:0]];
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state_q      <= R_IDLE;
      ARREADY        <= 1'b0;
      RVALID         <= 1'b0;
      RLAST          <= 1'b0;
      RID            <= '0;
      RDATA          <= '0;
      RRESP          <= RESP_OKAY;
      ar_idx_q       <= '0;
      ar_below_q     <= 1'b0;
      ar_len_q       <= '0;
      ar_burst_err_q <= 1'b0;
      r_cnt_q        <= '0;
    end else begin
      r_state_q <= r_state_d;
      ARREADY   <= (r_state_d == R_IDLE);
      RVALID    <= (r_state_d == R_DATA);
      if (ar_hs) begin
        RID            <= ARID;
        ar_idx_q       <= f_base;
        ar_below_q     <= f_below;
        ar_len_q       <= ARLEN;
        ar_burst_err_q <= f_err;
      end
      if (r_load) begin
        r_cnt_q <= f_cnt;
        RDATA   <= f_data;
        RRESP   <= f_resp;
        RLAST   <= (f_cnt == f_len);
      end else if (r_hs) begin
        RLAST   <= 1'b0;
      end
    end
  end

endmodule
